// File: rtl/serial_tx_4.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx_4 #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_end = (timer_q == TimerLast);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // The bit timer free-runs in every non-idle state and restarts at each bit boundary.
    if (state_q != StIdle) begin
      timer_d = bit_end ? '0 : timer_q + TimerW'(1);
    end

    case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d = StStart;
          shreg_d = i_d;
          timer_d = '0;
          idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^i_d;
`endif
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IdxLast) begin
            idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so every output comes straight off a flop.
  always_comb begin
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = ~ready_d;
    done_d  = (state_q == StStop) && (state_d == StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_serial_tx_4.sv
// Directed bench for serial_tx_4: one instance at one clock per bit, one at three clocks per bit.
// Expected line patterns are hand-written; bit i of each pattern is the line in frame cycle i+1.
module tb_serial_tx_4;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 7;
  localparam logic [NB-1:0] E1010 = 7'b1010100;
  localparam logic [NB-1:0] E0101 = 7'b1001010;
  localparam logic [NB-1:0] E0011 = 7'b1000110;
  localparam logic [NB-1:0] E0111 = 7'b1101110;
  localparam int NC = 21;
`else
  localparam int NB = 6;
  localparam logic [NB-1:0] E1010 = 6'b110100;
  localparam logic [NB-1:0] E0101 = 6'b101010;
  localparam logic [NB-1:0] E0011 = 6'b100110;
  localparam logic [NB-1:0] E0111 = 6'b101110;
  localparam int NC = 18;
`endif

  logic       clk;
  logic       rst_n;
  logic       valid1, valid3;
  logic [3:0] d1, d3;
  logic       ready1, tx1, busy1, done1;
  logic       ready3, tx3, busy3, done3;
  int         n_checks;
  int         n_fails;

  serial_tx_4 #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid1),
    .i_d     (d1),
    .o_ready (ready1),
    .o_tx    (tx1),
    .o_busy  (busy1),
    .o_done  (done1)
  );

  serial_tx_4 #(.WIDTH(4), .CLKS_PER_BIT(3)) u_dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid3),
    .i_d     (d3),
    .o_ready (ready3),
    .o_tx    (tx3),
    .o_busy  (busy3),
    .o_done  (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle1(input string tag, input logic exp_done);
    check({tag, "_tx"}, tx1, 1'b1);
    check({tag, "_ready"}, ready1, 1'b1);
    check({tag, "_busy"}, busy1, 1'b0);
    check({tag, "_done"}, done1, exp_done);
  endtask

  // Called in the first cycle after the accepting edge; returns in the done cycle.
  task automatic frame1(input string tag, input logic [NB-1:0] bits);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_tx%0d", tag, i), tx1, bits[i]);
      check($sformatf("%s_busy%0d", tag, i), busy1, 1'b1);
      check($sformatf("%s_ready%0d", tag, i), ready1, 1'b0);
      check($sformatf("%s_done%0d", tag, i), done1, 1'b0);
      step();
    end
    check_idle1({tag, "_end"}, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b1;
    valid1   = 1'b0;
    valid3   = 1'b0;
    d1       = 4'h0;
    d3       = 4'h0;

    // Asynchronous reset asserted between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_idle1("rst_async", 1'b0);
    check("rst_async_tx3", tx3, 1'b1);
    check("rst_async_ready3", ready3, 1'b1);
    step();
    step();
    check_idle1("rst_held", 1'b0);
    rst_n = 1'b1;
    step();
    step();
    check_idle1("rst_release", 1'b0);
    check("rst_release_busy3", busy3, 1'b0);
    check("rst_release_done3", done3, 1'b0);

    // Single frame, valid for one edge only.
    valid1 = 1'b1;
    d1     = 4'b1010;
    step();
    valid1 = 1'b0;
    d1     = 4'b0000;
    frame1("single", E1010);
    step();
    check_idle1("single_after", 1'b0);

    // Valid with new data during a frame must be ignored.
    valid1 = 1'b1;
    d1     = 4'b1010;
    step();
    d1 = 4'b1111;
    frame1("ignore", E1010);
    valid1 = 1'b0;
    step();
    check_idle1("ignore_after", 1'b0);
    step();
    check_idle1("ignore_after2", 1'b0);

    // Back-to-back frames: second word accepted in the done cycle.
    valid1 = 1'b1;
    d1     = 4'b0101;
    step();
    frame1("b2b_a", E0101);
    d1 = 4'b0011;
    step();
    frame1("b2b_b", E0011);
    valid1 = 1'b0;
    step();
    check_idle1("b2b_after", 1'b0);

    // Pattern with odd parity contribution.
    valid1 = 1'b1;
    d1     = 4'b0111;
    step();
    valid1 = 1'b0;
    frame1("d0111", E0111);
    step();
    check_idle1("d0111_after", 1'b0);

    // Three clocks per bit, word 0001.
    valid3 = 1'b1;
    d3     = 4'b0001;
    step();
    valid3 = 1'b0;
    for (int c = 1; c <= NC; c++) begin
      check($sformatf("cpb3_tx_c%0d", c), tx3, ((c >= 4) && (c <= 6)) || (c >= 16));
      check($sformatf("cpb3_busy_c%0d", c), busy3, 1'b1);
      check($sformatf("cpb3_done_c%0d", c), done3, 1'b0);
      step();
    end
    check("cpb3_done", done3, 1'b1);
    check("cpb3_ready", ready3, 1'b1);
    check("cpb3_tx_idle", tx3, 1'b1);
    step();
    check("cpb3_done_drop", done3, 1'b0);
    check("cpb3_busy_after", busy3, 1'b0);

    // Reset during data bit 2 of 1111.
    valid1 = 1'b1;
    d1     = 4'b1111;
    step();
    valid1 = 1'b0;
    step();
    step();
    step();
    check("midrst_busy_before", busy1, 1'b1);
    check("midrst_ready_before", ready1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle1("midrst_async", 1'b0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check_idle1($sformatf("midrst_after%0d", c), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
